// File: rtl/msa_schedule_expander_if.sv
// rtl/msa_schedule_expander_if.sv - chunk-in / schedule-out handshake bundle for the schedule expander
interface msa_schedule_expander_if;
  logic              chunk_vld;
  logic              chunk_rdy;
  logic [15:0][31:0] chunk;
  logic              w_rdy;
  logic              w_vld;
  logic [63:0][31:0] w;

  modport master (output chunk_vld, chunk, w_rdy, input chunk_rdy, w_vld, w);
  modport slave  (input chunk_vld, chunk, w_rdy, output chunk_rdy, w_vld, w);
endinterface

// File: rtl/msa_schedule_expander.sv
// rtl/msa_schedule_expander.sv - SHA-256 message schedule expansion (16 words -> 64 words)
module msa_schedule_expander #(
  parameter int WORDS_PER_CYCLE = 1,
  parameter bit BYTE_SWAP       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  msa_schedule_expander_if.slave  bus,
  output logic                    busy,
  output logic [31:0]             chunk_count
);
  localparam int         WPC      = WORDS_PER_CYCLE;
  localparam logic [5:0] LAST_IDX = 6'(64 - WPC);

  typedef enum logic [1:0] {INIT, LOAD, EXPAND, OUTPUT} state_t;

  state_t            state, state_nx;
  logic [63:0][31:0] w_q;
  logic [63:0][31:0] w_exp;
  logic [15:0][31:0] chunk_in;
  logic [5:0]        idx;
  logic [5:0]        wi;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  always_comb begin
    chunk_in = '0;
    for (int i = 0; i < 16; i++)
      chunk_in[i] = BYTE_SWAP ? bswap(bus.chunk[i]) : bus.chunk[i];
  end

  // Words within one cycle chain through w_exp, so W[i+1] sees the fresh W[i-1].
  always_comb begin
    w_exp = w_q;
    wi    = idx;
    for (int k = 0; k < WPC; k++) begin
      wi        = idx + 6'(k);
      w_exp[wi] = sig1(w_exp[wi - 6'd2]) + w_exp[wi - 6'd7]
                + sig0(w_exp[wi - 6'd15]) + w_exp[wi - 6'd16];
    end
  end

  always_comb begin
    state_nx      = state;
    bus.chunk_rdy = 1'b0;
    bus.w_vld     = 1'b0;
    busy          = 1'b0;
    case (state)
      INIT:   state_nx = LOAD;
      LOAD: begin
        bus.chunk_rdy = 1'b1;
        if (bus.chunk_vld) state_nx = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_nx = OUTPUT;
      end
      OUTPUT: begin
        busy      = 1'b1;
        bus.w_vld = 1'b1;
        if (bus.w_rdy) state_nx = LOAD;
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      w_q         <= '0;
      idx         <= '0;
      chunk_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: begin
          if (bus.chunk_vld) begin
            w_q[15:0] <= chunk_in;
            idx       <= 6'd16;
          end
        end
        EXPAND: begin
          w_q <= w_exp;
          idx <= idx + 6'(WPC);
        end
        OUTPUT: begin
          if (bus.w_rdy) chunk_count <= chunk_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.w = w_q;
endmodule

// File: tb/tb_msa_schedule_expander.sv
// tb/tb_msa_schedule_expander.sv - directed self-checking bench for msa_schedule_expander
module tb_msa_schedule_expander;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  msa_schedule_expander_if bi1 ();
  msa_schedule_expander_if bi4 ();
  msa_schedule_expander_if bi8 ();
  msa_schedule_expander_if bis ();
  logic        busy1, busy4, busy8, busys;
  logic [31:0] cnt1, cnt4, cnt8, cnts;

  msa_schedule_expander #(.WORDS_PER_CYCLE(1), .BYTE_SWAP(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bi1), .busy(busy1), .chunk_count(cnt1));
  msa_schedule_expander #(.WORDS_PER_CYCLE(4), .BYTE_SWAP(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(bi4), .busy(busy4), .chunk_count(cnt4));
  msa_schedule_expander #(.WORDS_PER_CYCLE(8), .BYTE_SWAP(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(bi8), .busy(busy8), .chunk_count(cnt8));
  msa_schedule_expander #(.WORDS_PER_CYCLE(1), .BYTE_SWAP(1'b1)) us (
    .clk(clk), .rst_n(rst_n), .bus(bis), .busy(busys), .chunk_count(cnts));

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [63:0][31:0] obs, input logic [63:0][31:0] exp);
    int bad;
    bad = 0;
    for (int i = 63; i >= 0; i--) if (obs[i] !== exp[i]) bad = i;
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s W[%0d] observed=%h expected=%h", tag, bad, obs[bad], exp[bad]);
    end
  endtask

  function automatic logic [63:0][31:0] model(input logic [15:0][31:0] c);
    logic [31:0]       m [64];
    logic [31:0]       a, b, s0, s1;
    logic [63:0][31:0] r;
    for (int i = 0; i < 16; i++) m[i] = c[i];
    for (int i = 16; i < 64; i++) begin
      a = m[i-15];
      b = m[i-2];
      s0 = {a[6:0], a[31:7]} ^ {a[17:0], a[31:18]} ^ {3'b000, a[31:3]};
      s1 = {b[16:0], b[31:17]} ^ {b[18:0], b[31:19]} ^ {10'd0, b[31:10]};
      m[i] = s1 + m[i-7] + s0 + m[i-16];
    end
    for (int i = 0; i < 64; i++) r[i] = m[i];
    return r;
  endfunction

  logic [15:0][31:0] abc, abc_sw, rc5;
  logic [15:0][31:0] rc [3];
  logic [63:0][31:0] exp_abc, zero_w;
  int l1, l4, l8, ls;
  int acc_n, got, last_acc, lat;
  bit pending;

  initial begin
    rst_n = 1'b0;
    bi1.chunk_vld = 0; bi4.chunk_vld = 0; bi8.chunk_vld = 0; bis.chunk_vld = 0;
    bi1.w_rdy = 0; bi4.w_rdy = 0; bi8.w_rdy = 0; bis.w_rdy = 0;
    abc = '0;
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;
    abc_sw = '0;
    abc_sw[0] = 32'h80636261;
    abc_sw[15] = 32'h18000000;
    zero_w = '0;
    exp_abc = model(abc);
    bi1.chunk = '0; bi4.chunk = '0; bi8.chunk = '0; bis.chunk = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_chunk_rdy", 32'(bi1.chunk_rdy), 32'd0);
    chk("rst_w_vld", 32'(bi1.w_vld), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_count", cnt1, 32'd0);
    chk_w("rst_w", bi1.w, zero_w);
    rst_n = 1'b1;
    chk("init_rdy_low", 32'(bi1.chunk_rdy), 32'd0);
    @(negedge clk);
    chk("load_rdy_u1", 32'(bi1.chunk_rdy), 32'd1);
    chk("load_rdy_u4", 32'(bi4.chunk_rdy), 32'd1);
    chk("load_rdy_u8", 32'(bi8.chunk_rdy), 32'd1);
    chk("load_rdy_us", 32'(bis.chunk_rdy), 32'd1);

    // "abc" chunk into all four; byte-swapped source into the BYTE_SWAP instance
    bi1.chunk = abc; bi4.chunk = abc; bi8.chunk = abc; bis.chunk = abc_sw;
    bi1.chunk_vld = 1; bi4.chunk_vld = 1; bi8.chunk_vld = 1; bis.chunk_vld = 1;
    @(negedge clk);
    bi4.chunk_vld = 0; bi8.chunk_vld = 0; bis.chunk_vld = 0;
    for (int i = 0; i < 16; i++) bi1.chunk[i] = $urandom;
    chk("busy_u1", 32'(busy1), 32'd1);
    chk("busy_u4", 32'(busy4), 32'd1);
    chk("busy_u8", 32'(busy8), 32'd1);
    chk("busy_us", 32'(busys), 32'd1);
    chk("expand_rdy_low", 32'(bi1.chunk_rdy), 32'd0);
    l1 = 0; l4 = 0; l8 = 0; ls = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      if (bi1.w_vld && l1 == 0) l1 = n;
      if (bi4.w_vld && l4 == 0) l4 = n;
      if (bi8.w_vld && l8 == 0) l8 = n;
      if (bis.w_vld && ls == 0) ls = n;
    end
    chk("latency_wpc1", l1, 32'd49);
    chk("latency_wpc4", l4, 32'd13);
    chk("latency_wpc8", l8, 32'd7);
    chk("latency_swap", ls, 32'd49);
    chk("abc_w16", bi1.w[16], 32'h61626380);
    chk("abc_w17", bi1.w[17], 32'h000F0000);
    chk("abc_w63", bi1.w[63], 32'h12B1EDEB);
    chk_w("abc_sched_wpc1", bi1.w, exp_abc);
    chk_w("abc_sched_wpc4", bi4.w, exp_abc);
    chk_w("abc_sched_wpc8", bi8.w, exp_abc);
    chk("swap_w0", bis.w[0], 32'h61626380);
    chk_w("abc_sched_swap", bis.w, exp_abc);

    // stall in OUTPUT with w_rdy low
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk_w("stall_w", bi1.w, exp_abc);
      chk("stall_w_vld", 32'(bi1.w_vld), 32'd1);
      chk("stall_rdy", 32'(bi1.chunk_rdy), 32'd0);
      chk("stall_count", cnt1, 32'd0);
    end
    bi1.w_rdy = 1; bi4.w_rdy = 1; bi8.w_rdy = 1; bis.w_rdy = 1;
    @(negedge clk);
    bi1.w_rdy = 0; bi4.w_rdy = 0; bi8.w_rdy = 0; bis.w_rdy = 0;
    bi1.chunk_vld = 0;
    chk("pop_count_u1", cnt1, 32'd1);
    chk("pop_count_u4", cnt4, 32'd1);
    chk("pop_count_u8", cnt8, 32'd1);
    chk("pop_count_us", cnts, 32'd1);
    chk("pop_rdy", 32'(bi1.chunk_rdy), 32'd1);
    chk("pop_w_vld", 32'(bi1.w_vld), 32'd0);

    // w_rdy outside OUTPUT has no effect
    bi1.w_rdy = 1;
    repeat (3) @(negedge clk);
    chk("idle_wrdy_count", cnt1, 32'd1);
    chk("idle_wrdy_busy", 32'(busy1), 32'd0);

    // back-to-back chunks with chunk_vld held high
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 16; i++) rc[j][i] = $urandom;
    bi1.chunk = rc[0];
    bi1.chunk_vld = 1;
    acc_n = 0; got = 0; last_acc = 0; pending = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (pending) begin
        pending = 0;
        acc_n++;
        if (acc_n < 3) bi1.chunk = rc[acc_n];
        else bi1.chunk_vld = 0;
      end
      if (bi1.w_vld) begin
        chk_w("b2b_sched", bi1.w, model(rc[got]));
        got++;
      end
      if (got == 3) break;
      if (bi1.chunk_rdy && bi1.chunk_vld) begin
        if (acc_n > 0) chk("b2b_spacing", cyc - last_acc, 32'd50);
        last_acc = cyc;
        pending = 1;
      end
      @(negedge clk);
    end
    chk("b2b_schedules", got, 32'd3);
    chk("b2b_accepts", acc_n, 32'd3);
    @(negedge clk);
    chk("b2b_count", cnt1, 32'd4);

    // reset while expanding at idx=40
    bi1.w_rdy = 0;
    for (int i = 0; i < 16; i++) rc5[i] = $urandom;
    bi1.chunk = rc5;
    bi1.chunk_vld = 1;
    @(negedge clk);
    bi1.chunk_vld = 0;
    repeat (24) @(negedge clk);
    chk("mid_busy", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_w_vld", 32'(bi1.w_vld), 32'd0);
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_count", cnt1, 32'd0);
    chk_w("mid_rst_w", bi1.w, zero_w);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy_low", 32'(bi1.chunk_rdy), 32'd0);
    @(negedge clk);
    chk("rel_rdy_high", 32'(bi1.chunk_rdy), 32'd1);
    bi1.chunk_vld = 1;
    @(negedge clk);
    bi1.chunk_vld = 0;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      if (bi1.w_vld) begin
        lat = n;
        break;
      end
    end
    chk("post_rst_latency", lat, 32'd49);
    chk_w("post_rst_sched", bi1.w, model(rc5));
    bi1.w_rdy = 1;
    @(negedge clk);
    chk("post_rst_count", cnt1, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
